// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - Elastic pipeline-stage register with one-entry skid buffer and event counters
module pipe_stage_buf #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 133,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire, out_fire;
  logic              load_main_in, load_main_skid, load_skid_in;
  logic              clear_main, clear_skid;

  // Flags decode straight from the state register, so out_ready never reaches in_ready.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign in_fire   = in_valid & in_ready & ~flush;
  assign out_fire  = out_valid & out_ready & ~flush;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    clear_main     = 1'b0;
    clear_skid     = 1'b0;
    if (flush) begin
      state_nxt  = EMPTY;
      clear_main = 1'b1;
      clear_skid = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt    = HALF;
            load_main_in = 1'b1;
          end
        end
        HALF: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            state_nxt    = FULL;
            load_skid_in = 1'b1;
          end else if (out_fire) begin
            state_nxt  = EMPTY;
            clear_main = 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt      = HALF;
            load_main_skid = 1'b1;
            clear_skid     = 1'b1;
          end
        end
        default: begin
          state_nxt  = EMPTY;
          clear_main = 1'b1;
          clear_skid = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Emptied entries are zeroed so an invalid output always reads as a harmless bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_ctrl  <= '0;
      out_data  <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (clear_main) begin
        out_ctrl <= '0;
        out_data <= '0;
      end else if (load_main_in) begin
        out_ctrl <= in_ctrl;
        out_data <= in_data;
      end else if (load_main_skid) begin
        out_ctrl <= skid_ctrl;
        out_data <= skid_data;
      end
      if (clear_skid) begin
        skid_ctrl <= '0;
        skid_data <= '0;
      end else if (load_skid_in) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && !flush && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (flush && state != EMPTY && flush_cnt != CNT_MAX) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule
